// File: rtl/sha2_pkg.sv
// Shared SHA-2 (256/224) constants, working-variable payload, FSM encoding and round functions.
package sha2_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned ROUNDS      = 64;
    localparam int unsigned BLOCK_WORDS = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } sha2_vars_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } sha2_state_e;

    localparam sha2_vars_t IV_256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam sha2_vars_t IV_224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam word_t K [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Lane-wise modulo-2^32 sum of two hash states.
    function automatic sha2_vars_t add_vars(input sha2_vars_t x, input sha2_vars_t y);
        sha2_vars_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha2_256_round.sv
// One combinational SHA-256 compression round: a..h plus Wt/Kt in, updated a..h out.
module sha2_256_round
    import sha2_pkg::*;
(
    input  logic [255:0] vars_i,
    input  logic [31:0]  w_i,
    input  logic [31:0]  k_i,
    output logic [255:0] vars_c
);

    sha2_vars_t v;
    word_t      t1;
    word_t      t2;

    always_comb begin
        v      = sha2_vars_t'(vars_i);
        t1     = v.h + big_sig1(v.e) + ch(v.e, v.f, v.g) + k_i + w_i;
        t2     = big_sig0(v.a) + maj(v.a, v.b, v.c);
        vars_c = {t1 + t2, v.a, v.b, v.c, v.d + t1, v.e, v.f, v.g};
    end

endmodule

// File: rtl/sha2_256_stream_core.sv
// Streaming SHA-256/SHA-224 engine: loads 16 words per block, runs UNROLL rounds per clock,
// chains blocks until the one flagged last, then publishes the digest.
module sha2_256_stream_core
    import sha2_pkg::*;
#(
    parameter int unsigned  UNROLL       = 1,
    parameter logic [255:0] RESET_DIGEST = 256'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode224,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid
);

    localparam logic [5:0] RND_LAST = 6'(ROUNDS - UNROLL);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("sha2_256_stream_core: UNROLL must be 1, 2 or 4");
    end

    sha2_state_e  state_q, state_d;
    sha2_vars_t   h_q, h_d;
    sha2_vars_t   work_q, work_d;
    word_t        w_q [BLOCK_WORDS];
    word_t        w_d [BLOCK_WORDS];
    word_t        w_adv [BLOCK_WORDS];
    logic [3:0]   wcnt_q, wcnt_d;
    logic [5:0]   rnd_q, rnd_d;
    logic         last_q, last_d;
    logic         mode_q, mode_d;
    logic         in_ready_q, in_ready_d;
    logic         busy_q, busy_d;
    logic         dv_q, dv_d;
    logic [255:0] digest_q, digest_d;

    logic [255:0] chain [UNROLL+1];
    word_t        w_rnd [UNROLL];
    word_t        k_rnd [UNROLL];

    // Message schedule: window holds W[t..t+15]; each round consumes W[t] and appends W[t+16].
    always_comb begin : p_sched
        word_t win [BLOCK_WORDS];
        word_t nxt;
        win = w_q;
        nxt = '0;
        for (int j = 0; j < int'(UNROLL); j++) begin
            w_rnd[j] = win[0];
            k_rnd[j] = K[rnd_q + 6'(j)];
            nxt      = small_sig1(win[14]) + win[9] + small_sig0(win[1]) + win[0];
            for (int i = 0; i < 15; i++) begin
                win[i] = win[i + 1];
            end
            win[15] = nxt;
        end
        w_adv = win;
    end

    assign chain[0] = work_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        sha2_256_round u_round (
            .vars_i (chain[g]),
            .w_i    (w_rnd[g]),
            .k_i    (k_rnd[g]),
            .vars_c (chain[g + 1])
        );
    end

    always_comb begin : p_next
        state_d  = state_q;
        h_d      = h_q;
        work_d   = work_q;
        w_d      = w_q;
        wcnt_d   = wcnt_q;
        rnd_d    = rnd_q;
        last_d   = last_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        dv_d     = dv_q;
        digest_d = digest_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // First DONE cycle publishes the hash finished in FINAL.
                if (state_q == ST_DONE && busy_q) begin
                    busy_d   = 1'b0;
                    dv_d     = 1'b1;
                    digest_d = {h_q.a, h_q.b, h_q.c, h_q.d, h_q.e, h_q.f, h_q.g,
                                (mode_q ? 32'h0 : h_q.h)};
                end
                if (start) begin
                    mode_d  = mode224;
                    h_d     = mode224 ? IV_224 : IV_256;
                    work_d  = mode224 ? IV_224 : IV_256;
                    dv_d    = 1'b0;
                    busy_d  = 1'b1;
                    wcnt_d  = '0;
                    rnd_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    for (int i = 0; i < 15; i++) begin
                        w_d[i] = w_q[i + 1];
                    end
                    w_d[15] = in_data;
                    wcnt_d  = wcnt_q + 4'd1;
                    if (wcnt_q == 4'd15) begin
                        last_d  = in_last;
                        state_d = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                work_d = sha2_vars_t'(chain[UNROLL]);
                w_d    = w_adv;
                rnd_d  = rnd_q + 6'(UNROLL);
                if (rnd_q == RND_LAST) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                h_d     = add_vars(h_q, work_q);
                work_d  = add_vars(h_q, work_q);
                state_d = last_q ? ST_DONE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            h_q        <= '0;
            work_q     <= '0;
            w_q        <= '{default: '0};
            wcnt_q     <= '0;
            rnd_q      <= '0;
            last_q     <= 1'b0;
            mode_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            dv_q       <= 1'b0;
            digest_q   <= RESET_DIGEST;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            work_q     <= work_d;
            w_q        <= w_d;
            wcnt_q     <= wcnt_d;
            rnd_q      <= rnd_d;
            last_q     <= last_d;
            mode_q     <= mode_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            dv_q       <= dv_d;
            digest_q   <= digest_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign digest       = digest_q;
    assign digest_valid = dv_q;

endmodule

// File: tb/tb_sha2_256_stream_core.sv
// Bench for sha2_256_stream_core: three instances (UNROLL 1/2/4) checked against known vectors
// and a plain-arithmetic SHA-2 reference model.
`timescale 1ns/1ps
module tb_sha2_256_stream_core;

    localparam int NDUT = 3;
    localparam logic [255:0] RST_DIG = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_0f0f0f0ff0f0f0f0;

    typedef logic [31:0] word_q_t[$];
    typedef logic [7:0]  byte_q_t[$];

    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] TIV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] TIV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                           32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
    localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] EMP256 = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode224;
    logic         in_valid     [NDUT];
    logic         in_last      [NDUT];
    logic [31:0]  in_data      [NDUT];
    logic         in_ready     [NDUT];
    logic         busy         [NDUT];
    logic         digest_valid [NDUT];
    logic [255:0] digest       [NDUT];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int t16    [NDUT];
    int t_done [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sha2_256_stream_core #(.UNROLL(1 << g), .RESET_DIGEST(RST_DIG)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start),
            .mode224      (mode224),
            .in_valid     (in_valid[g]),
            .in_ready     (in_ready[g]),
            .in_data      (in_data[g]),
            .in_last      (in_last[g]),
            .busy         (busy[g]),
            .digest       (digest[g]),
            .digest_valid (digest_valid[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_hash(input word_q_t m, input logic m224);
        logic [31:0] hh [8];
        logic [31:0] v  [8];
        logic [31:0] w  [64];
        logic [31:0] t1, t2;
        for (int i = 0; i < 8; i++) hh[i] = m224 ? TIV224[i] : TIV256[i];
        for (int b = 0; b < m.size() / 16; b++) begin
            for (int t = 0; t < 16; t++) w[t] = m[b * 16 + t];
            for (int t = 16; t < 64; t++)
                w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            for (int i = 0; i < 8; i++) v[i] = hh[i];
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
                t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
                v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) hh[i] = hh[i] + v[i];
        end
        return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], (m224 ? 32'h0 : hh[7])};
    endfunction

    function automatic word_q_t pad_msg(input byte_q_t b);
        byte_q_t     p;
        word_q_t     w;
        logic [63:0] bits;
        p    = b;
        bits = 64'(b.size()) << 3;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[i*8 +: 8]);
        for (int i = 0; i < p.size(); i += 4) w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
        return w;
    endfunction

    function automatic byte_q_t str_bytes(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // ---------------- drivers ----------------
    task automatic pulse_start(input logic m);
        @(negedge clk);
        start   = 1'b1;
        mode224 = m;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Streams words to one instance; random in_valid gaps and junk in_last on non-final words.
    task automatic feed(input int k, input word_q_t w, input int gap);
        int i     = 0;
        int guard = 0;
        while (i < w.size() && guard < 20000) begin
            in_valid[k] = ($urandom_range(99) >= gap);
            in_data[k]  = w[i];
            in_last[k]  = (i % 16 == 15) ? (i == w.size() - 1) : 1'($urandom_range(1));
            if (in_valid[k] && in_ready[k]) begin
                if (i % 16 == 15) t16[k] = cyc + 1;
                i++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
        total++;
        if (i != w.size()) $display("FAIL feed[%0d] words accepted %0d required %0d", k, i, w.size());
        else passed++;
    endtask

    task automatic wait_done(input int k, output int t);
        int guard = 0;
        while (!digest_valid[k] && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        t = digest_valid[k] ? cyc : -1;
    endtask

    task automatic run_one(input int k, input word_q_t w, input int gap);
        feed(k, w, gap);
        wait_done(k, t_done[k]);
    endtask

    task automatic run_all(input word_q_t w, input logic m, input int gap);
        pulse_start(m);
        fork
            run_one(0, w, gap);
            run_one(1, w, gap);
            run_one(2, w, gap);
        join
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            total++; if (digest[k] !== RST_DIG) $display("FAIL reset_digest[%0d] got %h exp %h", k, digest[k], RST_DIG); else passed++;
            total++; if (busy[k] !== 1'b0) $display("FAIL reset_busy[%0d] got %b exp 0", k, busy[k]); else passed++;
            total++; if (in_ready[k] !== 1'b0) $display("FAIL reset_in_ready[%0d] got %b exp 0", k, in_ready[k]); else passed++;
            total++; if (digest_valid[k] !== 1'b0) $display("FAIL reset_dv[%0d] got %b exp 0", k, digest_valid[k]); else passed++;
        end
        rst = 1'b0;
    endtask

    task automatic test_abc();
        word_q_t     w;
        logic [255:0] exp;
        int          lat;
        w = pad_msg(str_bytes("abc"));
        for (int m = 0; m < 2; m++) begin
            exp = (m == 0) ? ABC256 : ABC224;
            run_all(w, m[0], 0);
            for (int k = 0; k < NDUT; k++) begin
                lat = 64 / (1 << k) + 2;
                total++; if (digest[k] !== exp) $display("FAIL abc_digest[%0d] mode224=%0d got %h exp %h", k, m, digest[k], exp); else passed++;
                total++; if (t_done[k] - t16[k] !== lat) $display("FAIL abc_latency[%0d] got %0d exp %0d", k, t_done[k] - t16[k], lat); else passed++;
                total++; if (busy[k] !== 1'b0) $display("FAIL abc_busy[%0d] got %b exp 0", k, busy[k]); else passed++;
            end
        end
    endtask

    task automatic test_two_block();
        word_q_t w;
        w = pad_msg(str_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"));
        total++; if (w.size() !== 32) $display("FAIL two_block_pad size got %0d exp 32", w.size()); else passed++;
        run_all(w, 1'b0, 0);
        for (int k = 0; k < NDUT; k++) begin
            total++; if (digest[k] !== TWO256) $display("FAIL two_block_digest[%0d] got %h exp %h", k, digest[k], TWO256); else passed++;
            total++; if (t_done[k] - t16[k] !== 64 / (1 << k) + 2) $display("FAIL two_block_latency[%0d] got %0d exp %0d", k, t_done[k] - t16[k], 64 / (1 << k) + 2); else passed++;
        end
    endtask

    task automatic test_empty_gaps();
        word_q_t w;
        byte_q_t e;
        w = pad_msg(e);
        run_all(w, 1'b0, 40);
        for (int k = 0; k < NDUT; k++) begin
            total++; if (digest[k] !== EMP256) $display("FAIL empty_digest[%0d] got %h exp %h", k, digest[k], EMP256); else passed++;
            total++; if (t_done[k] - t16[k] !== 64 / (1 << k) + 2) $display("FAIL empty_latency[%0d] got %0d exp %0d", k, t_done[k] - t16[k], 64 / (1 << k) + 2); else passed++;
        end
    endtask

    task automatic test_random();
        byte_q_t      b;
        word_q_t      w;
        logic [255:0] exp;
        logic         m;
        int           len;
        for (int n = 0; n < 4; n++) begin
            b.delete();
            len = int'($urandom_range(130));
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            m   = 1'($urandom_range(1));
            w   = pad_msg(b);
            exp = ref_hash(w, m);
            run_all(w, m, int'($urandom_range(50)));
            for (int k = 0; k < NDUT; k++) begin
                total++; if (digest[k] !== exp) $display("FAIL random_digest[%0d] len=%0d got %h exp %h", k, len, digest[k], exp); else passed++;
            end
            repeat (4) @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                total++; if (digest[k] !== exp || digest_valid[k] !== 1'b1)
                    $display("FAIL random_hold[%0d] got %h/%b exp %h/1", k, digest[k], digest_valid[k], exp);
                else passed++;
            end
        end
    endtask

    task automatic test_start_ignored_and_reset();
        word_q_t w;
        w = pad_msg(str_bytes("abc"));
        pulse_start(1'b0);
        fork
            feed(0, w, 0);
            feed(1, w, 0);
            feed(2, w, 0);
        join
        pulse_start(1'b1);
        fork
            wait_done(0, t_done[0]);
            wait_done(1, t_done[1]);
            wait_done(2, t_done[2]);
        join
        for (int k = 0; k < NDUT; k++) begin
            total++; if (digest[k] !== ABC256) $display("FAIL start_in_round[%0d] got %h exp %h", k, digest[k], ABC256); else passed++;
        end
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NDUT; k++) begin
                in_valid[k] = 1'b1;
                in_data[k]  = $urandom;
                in_last[k]  = 1'b0;
            end
            @(negedge clk);
        end
        for (int k = 0; k < NDUT; k++) begin
            total++; if (busy[k] !== 1'b1 || in_ready[k] !== 1'b1) $display("FAIL mid_block[%0d] busy/ready got %b/%b exp 1/1", k, busy[k], in_ready[k]); else passed++;
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k] = 1'b0;
            total++; if (digest[k] !== RST_DIG) $display("FAIL mid_rst_digest[%0d] got %h exp %h", k, digest[k], RST_DIG); else passed++;
            total++; if (busy[k] !== 1'b0 || in_ready[k] !== 1'b0 || digest_valid[k] !== 1'b0)
                $display("FAIL mid_rst_flags[%0d] busy/ready/dv got %b/%b/%b exp 0/0/0", k, busy[k], in_ready[k], digest_valid[k]);
            else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
        run_all(w, 1'b0, 10);
        for (int k = 0; k < NDUT; k++) begin
            total++; if (digest[k] !== ABC256) $display("FAIL after_rst_digest[%0d] got %h exp %h", k, digest[k], ABC256); else passed++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        mode224 = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k] = 1'b0;
            in_last[k]  = 1'b0;
            in_data[k]  = '0;
            t16[k]      = 0;
            t_done[k]   = 0;
        end
        test_reset();
        test_abc();
        test_two_block();
        test_empty_gaps();
        test_random();
        test_start_ignored_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
